// File: rtl/rv16_pkg.sv
// rv16 shared decode types and constants.
// Opcode map, field positions and control bundle.
package rv16_pkg;

  localparam int RV16_DATA_W     = 16;
  localparam int RV16_REG_ADDR_W = 4;
  localparam int RV16_NUM_REGS   = 16;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 0;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_SLL   = 4'h5,
    OP_SRL   = 4'h6,
    OP_SLT   = 4'h7,
    OP_ADDI  = 4'h8,
    OP_LOAD  = 4'h9,
    OP_STORE = 4'hA,
    OP_BEQ   = 4'hB,
    OP_JAL   = 4'hC,
    OP_LUI   = 4'hD,
    OP_NOP   = 4'hE,
    OP_HALT  = 4'hF
  } opcode_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic uses_rs1;
    logic uses_rs2;
  } ctrl_t;

endpackage

// File: rtl/rv16_scoreboard.sv
// rv16 pending-write scoreboard.
// Tracks issued writers and answers source-busy lookups.
module rv16_scoreboard
  import rv16_pkg::*;
#(
  parameter int REG_ADDR_W = RV16_REG_ADDR_W,
  parameter int NUM_REGS   = RV16_NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic                  fwd_en,
  input  logic [REG_ADDR_W-1:0] fwd_addr,
  input  logic                  q1_en,
  input  logic [REG_ADDR_W-1:0] q1_addr,
  input  logic                  q2_en,
  input  logic [REG_ADDR_W-1:0] q2_addr,
  output logic                  q1_busy,
  output logic                  q2_busy,
  output logic [NUM_REGS-1:0]   bits
);

  logic [NUM_REGS-1:0] bits_n;

  // A retiring writeback bypasses its bit; the
  // output register's own writer always blocks.
  function automatic logic busy(
    input logic                  en,
    input logic [REG_ADDR_W-1:0] a
  );
    logic pend;
    logic fwd;
    pend = bits[a] && !(clr_en && clr_addr == a);
    fwd  = fwd_en && fwd_addr == a;
    return en && (a != '0) && (pend || fwd);
  endfunction

  assign q1_busy = busy(q1_en, q1_addr);
  assign q2_busy = busy(q2_en, q2_addr);

  // Next bitmap: clear on writeback, set wins, r0 never pending.
  always_comb begin
    bits_n = bits;
    if (clr_en) bits_n[clr_addr] = 1'b0;
    if (set_en) bits_n[set_addr] = 1'b1;
    bits_n[0] = 1'b0;
  end

  // Bitmap register.
  always_ff @(posedge clk) begin
    if (rst) bits <= '0;
    else     bits <= bits_n;
  end

endmodule

// File: rtl/rv16_decode_stage.sv
// rv16 decode/issue stage.
// Decodes fetch words, stalls on RAW, feeds regfile/execute.
module rv16_decode_stage
  import rv16_pkg::*;
#(
  parameter int DATA_W     = RV16_DATA_W,
  parameter int REG_ADDR_W = RV16_REG_ADDR_W,
  parameter int NUM_REGS   = RV16_NUM_REGS
) (
  input  logic                  rv16_dec_clock,
  input  logic                  rv16_dec_reset,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [15:0]           if_instr,
  input  logic [DATA_W-1:0]     if_pc,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [DATA_W-1:0]     id_pc,
  output logic [3:0]            id_opcode,
  output logic [REG_ADDR_W-1:0] id_rd_addr,
  output logic [REG_ADDR_W-1:0] id_rs1_addr,
  output logic [REG_ADDR_W-1:0] id_rs2_addr,
  output logic [DATA_W-1:0]     id_imm,
  output logic                  id_reg_write,
  output logic                  id_mem_read,
  output logic                  id_mem_write,
  output logic                  id_branch,
  output logic                  id_jump,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  flush,
  output logic                  halted,
  output logic [NUM_REGS-1:0]   scoreboard
);

  typedef struct packed {
    ctrl_t                 ctrl;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [DATA_W-1:0]     imm;
  } dec_t;

  function automatic dec_t decode(input logic [15:0] ins);
    dec_t                d;
    opcode_e             op;
    logic [DATA_W-1:0]   imm4;
    logic [DATA_W-1:0]   imm8;
    logic [DATA_W-1:0]   immu;
    op   = opcode_e'(ins[OP_HI:OP_LO]);
    imm4 = {{(DATA_W-4){ins[3]}}, ins[3:0]};
    imm8 = {{(DATA_W-8){ins[7]}}, ins[7:0]};
    immu = DATA_W'(ins[7:0]) << 8;
    d     = '0;
    d.rd  = REG_ADDR_W'(ins[RD_HI:RD_LO]);
    d.rs1 = REG_ADDR_W'(ins[RS1_HI:RS1_LO]);
    d.rs2 = REG_ADDR_W'(ins[RS2_HI:RS2_LO]);
    unique case (1'b1)
      (ins[OP_HI] == 1'b0): begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.uses_rs1  = 1'b1;
        d.ctrl.uses_rs2  = 1'b1;
      end
      (op == OP_ADDI): begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.uses_rs1  = 1'b1;
        d.imm            = imm4;
      end
      (op == OP_LOAD): begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.mem_read  = 1'b1;
        d.ctrl.uses_rs1  = 1'b1;
        d.imm            = imm4;
      end
      (op == OP_STORE): begin
        d.ctrl.mem_write = 1'b1;
        d.ctrl.uses_rs1  = 1'b1;
        d.ctrl.uses_rs2  = 1'b1;
        d.rs2            = d.rd;
        d.imm            = imm4;
      end
      (op == OP_BEQ): begin
        d.ctrl.branch    = 1'b1;
        d.ctrl.uses_rs1  = 1'b1;
        d.ctrl.uses_rs2  = 1'b1;
        d.rs2            = d.rd;
        d.imm            = imm4;
      end
      (op == OP_JAL): begin
        d.ctrl.jump      = 1'b1;
        d.ctrl.reg_write = 1'b1;
        d.imm            = imm8;
      end
      (op == OP_LUI): begin
        d.ctrl.reg_write = 1'b1;
        d.imm            = immu;
      end
      default: begin
      end
    endcase
    if (d.rd == '0) d.ctrl.reg_write = 1'b0;
    return d;
  endfunction

  dec_t dec;
  logic busy1;
  logic busy2;
  logic hazard;
  logic if_fire;
  logic id_fire;

  assign dec     = decode(if_instr);
  assign hazard  = busy1 || busy2;
  assign id_fire = id_valid && id_ready;
  assign if_ready = (!id_valid || id_ready)
                 && !hazard && !halted && !flush;
  assign if_fire = if_valid && if_ready;

  rv16_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_REGS   (NUM_REGS)
  ) u_sb (
    .clk      (rv16_dec_clock),
    .rst      (rv16_dec_reset),
    .set_en   (id_fire && id_reg_write),
    .set_addr (id_rd_addr),
    .clr_en   (wb_valid),
    .clr_addr (wb_rd_addr),
    .fwd_en   (id_valid && id_reg_write),
    .fwd_addr (id_rd_addr),
    .q1_en    (dec.ctrl.uses_rs1),
    .q1_addr  (dec.rs1),
    .q2_en    (dec.ctrl.uses_rs2),
    .q2_addr  (dec.rs2),
    .q1_busy  (busy1),
    .q2_busy  (busy2),
    .bits     (scoreboard)
  );

  // Output register: load on accept, drain on handshake or flush.
  always_ff @(posedge rv16_dec_clock) begin
    if (rv16_dec_reset) begin
      id_valid     <= 1'b0;
      id_pc        <= '0;
      id_opcode    <= '0;
      id_rd_addr   <= '0;
      id_rs1_addr  <= '0;
      id_rs2_addr  <= '0;
      id_imm       <= '0;
      id_reg_write <= 1'b0;
      id_mem_read  <= 1'b0;
      id_mem_write <= 1'b0;
      id_branch    <= 1'b0;
      id_jump      <= 1'b0;
    end else if (if_fire) begin
      id_valid     <= 1'b1;
      id_pc        <= if_pc;
      id_opcode    <= if_instr[OP_HI:OP_LO];
      id_rd_addr   <= dec.rd;
      id_rs1_addr  <= dec.rs1;
      id_rs2_addr  <= dec.rs2;
      id_imm       <= dec.imm;
      id_reg_write <= dec.ctrl.reg_write;
      id_mem_read  <= dec.ctrl.mem_read;
      id_mem_write <= dec.ctrl.mem_write;
      id_branch    <= dec.ctrl.branch;
      id_jump      <= dec.ctrl.jump;
    end else if (flush || id_ready) begin
      id_valid     <= 1'b0;
    end
  end

  // Sticky halt, raised when HALT enters the output register.
  always_ff @(posedge rv16_dec_clock) begin
    if (rv16_dec_reset || flush) halted <= 1'b0;
    else if (if_fire && if_instr[OP_HI:OP_LO] == OP_HALT)
      halted <= 1'b1;
  end

endmodule
